// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage hold vector, exception flush sequencing, stall counter and EX watchdog.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int EX_TIMEOUT   = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             excp_req,
    input  logic [31:0]      excp_pc,
    input  logic             cnt_clr,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err_timeout,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

    state_t     cur, nxt;
    logic [3:0] flush_left;
    logic [7:0] wd;
    logic       in_flush, accept;

    assign in_flush = cur == FLUSH;
    assign accept   = (cur == RUN || cur == STALL) && excp_req;
    assign flush    = in_flush;
    assign state    = cur;

    always_comb begin
        nxt = RUN;
        if (in_flush)
            nxt = flush_left == 4'd1 ? RUN : FLUSH;
        else if (cur == RUN || cur == STALL)
            nxt = excp_req ? FLUSH : (stallreq_ex | stallreq_id) ? STALL : RUN;
        stall = in_flush    ? 6'b000000 :
                excp_req    ? 6'b011111 :
                stallreq_ex ? 6'b001111 :
                stallreq_id ? 6'b000111 : 6'b000000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur        <= RUN;
            flush_left <= '0;
            new_pc     <= '0;
        end else begin
            cur <= nxt;
            if (accept) begin
                flush_left <= 4'(FLUSH_CYCLES);
                new_pc     <= excp_pc;
            end else if (in_flush) begin
                flush_left <= flush_left - 4'd1;
            end
        end
    end

    // Clear wins over increment; the counter sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (cnt_clr)
            stall_cnt <= '0;
        else if (stall[0] && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd          <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (!stallreq_ex || in_flush)
                wd <= '0;
            else if (wd != 8'hFF)
                wd <= wd + 8'd1;
            if (stallreq_ex && !in_flush && wd >= 8'(EX_TIMEOUT - 1))
                err_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against an in-bench behavioural model.
module tb_pipe_ctrl;
    localparam int FC   = 3;
    localparam int TO   = 4;
    localparam int W    = 4;
    localparam int CMAX = (1 << W) - 1;

    logic          clk = 0, rst = 0;
    logic          stallreq_id = 0, stallreq_ex = 0, excp_req = 0, cnt_clr = 0;
    logic [31:0]   excp_pc = 0;
    logic [5:0]    stall;
    logic          flush, err_timeout;
    logic [31:0]   new_pc;
    logic [W-1:0]  stall_cnt;
    logic [1:0]    state;

    int n_cmp = 0, n_bad = 0;

    pipe_ctrl #(.FLUSH_CYCLES(FC), .EX_TIMEOUT(TO), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .excp_req(excp_req), .excp_pc(excp_pc), .cnt_clr(cnt_clr), .stall(stall),
        .flush(flush), .new_pc(new_pc), .stall_cnt(stall_cnt), .err_timeout(err_timeout),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Model: flushing is a window of edge indices; the watchdog is a run length of EX requests.
    int          edge_idx = 0, flush_to = -1, m_cnt = 0, m_streak = 0, m_state = 0;
    bit          m_flush = 0, m_err = 0, was_flush;
    logic [31:0] m_pc = 0;
    logic [5:0]  s_now;

    function automatic logic [5:0] exp_stall();
        if (m_flush)     return 6'h00;
        if (excp_req)    return 6'h1F;
        if (stallreq_ex) return 6'h0F;
        if (stallreq_id) return 6'h07;
        return 6'h00;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_idx = 0; flush_to = -1; m_flush = 0; m_pc = 0;
            m_cnt = 0; m_streak = 0; m_err = 0; m_state = 0;
        end else begin
            was_flush = m_flush;
            s_now = exp_stall();
            edge_idx++;
            if (cnt_clr) m_cnt = 0;
            else if (s_now[0]) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
            m_streak = (!was_flush && stallreq_ex) ? m_streak + 1 : 0;
            if (m_streak >= TO) m_err = 1;
            if (!was_flush && excp_req) begin
                m_pc = excp_pc;
                flush_to = edge_idx + FC - 1;
            end
            m_flush = edge_idx <= flush_to;
            m_state = m_flush ? 2 : (!was_flush && (stallreq_ex || stallreq_id)) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        chk("stall", stall, exp_stall());
        chk("flush", flush, m_flush);
        chk("new_pc", new_pc, m_pc);
        chk("stall_cnt", stall_cnt, m_cnt);
        chk("err_timeout", err_timeout, m_err);
        chk("state", state, m_state);
    end

    task automatic cyc(input logic id, input logic ex, input logic xr,
                       input logic [31:0] pc, input logic clr);
        @(posedge clk);
        #1;
        stallreq_id = id; stallreq_ex = ex; excp_req = xr; excp_pc = pc; cnt_clr = clr;
    endtask

    initial begin
        stallreq_id = 1; stallreq_ex = 1; excp_req = 1; excp_pc = 32'h44; cnt_clr = 0;
        #3;
        chk("rst_stall", stall, 6'b011111);
        chk("rst_flush", flush, 0);
        chk("rst_state", state, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_pc", new_pc, 0);
        #20;
        stallreq_id = 0; stallreq_ex = 0; excp_req = 0;
        rst = 1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        #3 chk("no_flush", flush, 0);

        repeat (3) cyc(1, 0, 0, 0, 0);
        #3 chk("id_stall", stall, 6'b000111);
        cyc(0, 0, 0, 0, 0);
        #3;
        chk("id_state", state, 1);
        chk("id_cnt", stall_cnt, 3);

        cyc(1, 1, 0, 0, 0);
        #3 chk("prio_ex", stall, 6'b001111);
        cyc(1, 1, 1, 32'h20, 0);
        #3 chk("prio_excp", stall, 6'b011111);
        cyc(0, 0, 0, 0, 0);
        #3;
        chk("flush1", flush, 1);
        chk("flush_pc", new_pc, 32'h20);
        chk("flush_stall", stall, 0);
        cyc(0, 0, 1, 32'h99, 0);
        #3 chk("flush2", flush, 1);
        cyc(0, 0, 0, 0, 0);
        #3 chk("flush3", flush, 1);
        cyc(0, 0, 0, 0, 0);
        #3;
        chk("flush_end", flush, 0);
        chk("flush_run", state, 0);
        chk("flush_pc_hold", new_pc, 32'h20);

        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        #3 chk("wd_short", err_timeout, 0);
        repeat (4) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        #3 chk("wd_fire", err_timeout, 1);
        repeat (3) cyc(0, 0, 0, 0, 0);
        #3 chk("wd_sticky", err_timeout, 1);

        repeat (20) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        #3 chk("cnt_sat", stall_cnt, 15);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        #3 chk("cnt_clr", stall_cnt, 0);
        cyc(0, 0, 0, 0, 0);
        #3 chk("cnt_restart", stall_cnt, 1);

        cyc(0, 0, 1, 32'hABC0, 0);
        cyc(0, 0, 0, 0, 0);
        #2 chk("pre_arst_flush", flush, 1);
        rst = 0;
        #1;
        chk("arst_flush", flush, 0);
        chk("arst_state", state, 0);
        chk("arst_err", err_timeout, 0);
        #4 rst = 1;
        repeat (3) cyc(0, 0, 0, 0, 0);
        #3 chk("no_resume", flush, 0);

        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 24) == 0);
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 0;
                #3 rst = 1;
            end
        end
        cyc(0, 0, 0, 0, 0);
        @(posedge clk);
        #6;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush controller for the five-stage core. Combines hazard stall requests from ID and multi-cycle-busy requests from EX into the per-stage hold vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sequences exception flushes and supplies the redirect PC. It also keeps a saturating stall-cycle counter and an EX-stall watchdog.

## Interface
Parameters:
- FLUSH_CYCLES, default 1: cycles `flush` stays high per accepted exception (1..15).
- EX_TIMEOUT, default 64: consecutive `stallreq_ex` cycles before `err_timeout` sets (2..255).
- CNT_W, default 32: width of `stall_cnt`.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; low clears all state immediately.
- stallreq_id  in  1  ID load-use hazard; hold PC, IF/ID and ID/EX.
- stallreq_ex  in  1  EX multi-cycle op busy; hold PC, IF/ID, ID/EX and EX/MEM.
- excp_req  in  1  exception detected in MEM; one-cycle pulse.
- excp_pc  in  32  handler address, valid with `excp_req`.
- cnt_clr  in  1  synchronous clear of `stall_cnt`.
- stall  out  6  hold vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = hold.
- flush  out  1  clears IF/ID, ID/EX and EX/MEM to NOP.
- new_pc  out  32  redirect target, valid while `flush` = 1.
- stall_cnt  out  CNT_W  cycles with stall[0] = 1, saturating.
- err_timeout  out  1  sticky: EX stalled ≥ EX_TIMEOUT consecutive cycles.
- state  out  2  FSM state (debug).

## Operation
- FSM states: RUN = 0, STALL = 1, FLUSH = 2. The value 3 is unreachable and recovers to RUN.
- Next state from RUN or STALL:
  - FLUSH if `excp_req`;
  - else STALL if `stallreq_ex | stallreq_id`;
  - else RUN.
- FLUSH loads `flush_left` = FLUSH_CYCLES and latches `excp_pc` into `new_pc`. `flush_left` decrements each cycle. FLUSH exits to RUN in the cycle `flush_left` reaches 1.
- All of `excp_req`, `stallreq_id` and `stallreq_ex` are ignored while in FLUSH.
- `stall` is combinational (Mealy), with priority excp > ex > id:
  - state FLUSH: `6'b000000`;
  - `excp_req` = 1: `6'b011111` (freeze everything younger than WB for one cycle before flush);
  - `stallreq_ex`: `6'b001111`;
  - `stallreq_id`: `6'b000111`;
  - otherwise `6'b000000`.
- `flush` is registered: 1 exactly while state = FLUSH.
- `new_pc` holds its last value outside FLUSH.
- `stall_cnt` increments when stall[0] = 1 and saturates at 2^CNT_W−1. `cnt_clr` has priority over increment, and the counter reads 0 on the next cycle.
- Watchdog counter (8 bit):
  - increments each cycle `stallreq_ex` = 1 outside FLUSH;
  - clears whenever `stallreq_ex` = 0 or state = FLUSH.
  - When it reaches EX_TIMEOUT−1 while `stallreq_ex` is still 1, `err_timeout` sets at the next edge.
  - `err_timeout` clears only by reset.

## Timing
- Reset values: state RUN, `flush` 0, `new_pc` 0, `stall_cnt` 0, `err_timeout` 0, `stall` 0 (requests low), internal counters 0.
- Asserting `rst` low mid-FLUSH drops `flush` immediately, with no edge required. The flush is not resumed after reset release.
- Stall latency is 0 cycles: `stall` follows the requests in the same cycle.
- Flush latency is 1 cycle: `excp_req` high at edge N means `flush` = 1 for cycles N+1 … N+FLUSH_CYCLES, then RUN.
- Simultaneous `excp_req` and a stall request: the exception wins and `stall` = `6'b011111` that cycle.
- Back-to-back `excp_req` on the last FLUSH cycle is dropped. Requesters must re-assert.
- `cnt_clr` and increment in the same cycle: the counter becomes 0.

## Test plan
- Reset: drive `rst` = 0 with all requests high. All outputs are 0 except `stall`, which follows the combinational rule, and state = 0. Release reset; hold `excp_req` = 0 → no flush.
- ID stall: `stallreq_id` = 1 for 3 cycles → `stall` = `6'b000111` in those cycles, state = STALL at the next edges, `stall_cnt` = 3.
- Priority: `stallreq_id` = `stallreq_ex` = 1 → `6'b001111`. Add `excp_req` with `excp_pc` = `0x0000_0020` → `6'b011111`. Next cycle `flush` = 1, `new_pc` = `0x20`, `stall` = 0.
- FLUSH_CYCLES = 3: one `excp_req` pulse → `flush` high exactly 3 cycles. A second pulse in flush cycle 2 is ignored. State then returns to RUN.
- Watchdog with EX_TIMEOUT = 4:
  - `stallreq_ex` high 3 cycles, low 1, high 3 → `err_timeout` stays 0;
  - high 4 consecutive cycles → `err_timeout` = 1 and stays 1 until reset.
- Counter: CNT_W = 4, 20 stall cycles → `stall_cnt` = 15. Pulse `cnt_clr` during a stall → 0 next cycle. Also assert `rst` low mid-flush → `flush` drops asynchronously.
